game_screen_ctrl: RTL and testbench
===================================

# game_screen_ctrl

Screen-sequencing controller for the game's VGA path. It owns the top-level game flow: power-up, intro, menu, tutorial, play, win and lose. It drives the 4-bit `vga_control` selector and the `blink` strobe consumed directly downstream by the VGA output multiplexer. It also issues start and run controls to the play-field logic and accepts its win/lose events.

## Interface
- `PWRUP_CYC`, default 100: cycles held in OFF after reset release before entering INTRO.
- `BLINK_HALF`, default 25_000_000: cycles per blink half-period in INTRO.
- `RESULT_CYC`, default 250_000_000: cycles WIN/LOSE screens are held before auto-return to MENU.
- `clk` in 1: system clock; all state updates on the rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `btn_start` in 1: start/confirm button, debounced level, asynchronous to `clk`.
- `btn_sel` in 1: menu select button, debounced level, asynchronous to `clk`.
- `win_evt` in 1: play-field win pulse, synchronous to `clk`.
- `lose_evt` in 1: play-field lose pulse, synchronous to `clk`.
- `vga_control` out 4: screen select. 0 = OFF, 1 = INTRO, 2 = MENU, 3 = TUTORIAL, 4 = PLAY, 5 = WIN, 6 = LOSE. Values 7–15 are never driven.
- `blink` out 1: intro blank strobe; 1 means the intro screen is blanked.
- `menu_item` out 1: highlighted menu entry. 0 = PLAY, 1 = TUTORIAL.
- `game_run` out 1: high while in PLAY.
- `game_start` out 1: one-cycle pulse on entry to PLAY.

## Operation
- Button front end:
  - Each button passes through a 2-flop synchronizer, then a third flop.
  - The edge signal is `sync2 & ~sync3`, giving exactly one cycle per press.
  - Held buttons do not repeat.
- State machine. `vga_control` is the registered state encoding.
- OFF: a counter runs 0 to PWRUP_CYC-1, then the block moves to INTRO. Buttons are ignored.
- INTRO:
  - The blink counter runs 0 to BLINK_HALF-1. On wrap, `blink` toggles.
  - The counter and `blink` clear to 0 on entry.
  - On a start edge, the block moves to MENU.
- MENU:
  - A select edge toggles `menu_item`.
  - A start edge with `menu_item`=0 moves to PLAY; with `menu_item`=1 it moves to TUTORIAL.
  - If start and select edges occur in the same cycle, start wins and `menu_item` is unchanged.
- TUTORIAL: a start edge moves to MENU. `menu_item` is retained.
- PLAY:
  - `win_evt` moves to WIN; `lose_evt` moves to LOSE.
  - If both occur in the same cycle, LOSE wins.
  - Button edges are ignored.
- WIN/LOSE:
  - The result counter clears on entry and runs 0 to RESULT_CYC-1, then the block moves to MENU.
  - A start edge moves to MENU early.
  - On return, `menu_item` is forced to 0.
- `win_evt`/`lose_evt` outside PLAY are ignored.
- `blink` is 0 in every state except INTRO.
- `game_run` = (state == PLAY).
- `game_start` is high for exactly the cycle after the MENU→PLAY transition edge, i.e. the first PLAY cycle.
- Counter widths are `$clog2` of the respective parameter, minimum 1. Counters never exceed parameter-1.
- Only the counter of the current state runs; the others hold at 0.

## Timing
- All outputs are registered and change only on `clk` rising edges or on `clr` assertion.
- Reset values: `vga_control`=0, `blink`=0, `menu_item`=0, `game_run`=0, `game_start`=0. All counters and sync flops are 0.
- `clr` low mid-operation forces reset values immediately, regardless of `clk`.
- After `clr` rises, the first clock edge counts OFF cycle 0. `vga_control` becomes 1 after edge PWRUP_CYC.
- Button latency: a level first sampled high at edge k updates state at edge k+2.
- Event latency: `win_evt` high during the cycle before edge k gives `vga_control`=5 after edge k.
- Blink: after INTRO entry, `blink` rises after BLINK_HALF edges, falls after 2×BLINK_HALF edges, and so on, with a 50% duty cycle.
- Result timeout: after WIN/LOSE entry at edge e, `vga_control` becomes 2 after edge e+RESULT_CYC.

## Test plan
- Reset and power-up (PWRUP_CYC=4): release `clr` → `vga_control`=0 for 4 edges, then 1; `blink`=0 on entry.
- Blink (BLINK_HALF=3): idle in INTRO → `blink` pattern 0,0,0,1,1,1,0…; press start → `vga_control`=2 two edges after sampling and `blink`=0.
- Menu navigation: in MENU, select pulse → `menu_item`=1; start → `vga_control`=3; start → 2 with `menu_item`=1; select → 0; start → 4 with `game_start` high exactly 1 cycle and `game_run`=1.
- Events: in PLAY, assert `win_evt` and `lose_evt` together → `vga_control`=6. Separately, `win_evt` in MENU → no change.
- Result exit (RESULT_CYC=5): in WIN, no input → `vga_control`=2 after 5 edges with `menu_item`=0. Repeat with start after 2 edges → early exit to MENU.
- Async reset mid-PLAY: drop `clr` between edges → all outputs 0 immediately. Hold start high through reset release → no spurious edge acted on in OFF.

Source files
------------

// File: rtl/game_screen_if.sv
// rtl/game_screen_if.sv - signal bundle between the screen controller and its surroundings
interface game_screen_if;
  logic       btn_start;
  logic       btn_sel;
  logic       win_evt;
  logic       lose_evt;
  logic [3:0] vga_control;
  logic       blink;
  logic       menu_item;
  logic       game_run;
  logic       game_start;

  modport master (
    output btn_start, btn_sel, win_evt, lose_evt,
    input  vga_control, blink, menu_item, game_run, game_start
  );

  modport slave (
    input  btn_start, btn_sel, win_evt, lose_evt,
    output vga_control, blink, menu_item, game_run, game_start
  );
endinterface

// File: rtl/game_screen_ctrl.sv
// rtl/game_screen_ctrl.sv - top-level game flow sequencer driving the VGA screen selector
module game_screen_ctrl #(
  parameter int PWRUP_CYC  = 100,
  parameter int BLINK_HALF = 25_000_000,
  parameter int RESULT_CYC = 250_000_000
) (
  input  logic         clk,
  input  logic         clr,
  game_screen_if.slave gs
);
  localparam int PW = (PWRUP_CYC  > 1) ? $clog2(PWRUP_CYC)  : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int RW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
  localparam logic [PW-1:0] PWR_LAST   = PW'(PWRUP_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [RW-1:0] RES_LAST   = RW'(RESULT_CYC - 1);

  // Encoding doubles as the vga_control screen code.
  typedef enum logic [3:0] {
    S_OFF   = 4'd0,
    S_INTRO = 4'd1,
    S_MENU  = 4'd2,
    S_TUT   = 4'd3,
    S_PLAY  = 4'd4,
    S_WIN   = 4'd5,
    S_LOSE  = 4'd6
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pwr_cnt, pwr_cnt_nx;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic [RW-1:0] res_cnt, res_cnt_nx;
  logic          blink, blink_nx;
  logic          menu_item, menu_item_nx;
  logic          game_run, game_run_nx;
  logic          game_start, game_start_nx;
  logic [2:0]    start_sync, sel_sync;
  logic          start_edge, sel_edge;

  // Bits [1:0] synchronize, bit [2] delays once more for rising-edge detection.
  assign start_edge = start_sync[1] & ~start_sync[2];
  assign sel_edge   = sel_sync[1] & ~sel_sync[2];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_OFF;
      pwr_cnt    <= '0;
      blink_cnt  <= '0;
      res_cnt    <= '0;
      blink      <= 1'b0;
      menu_item  <= 1'b0;
      game_run   <= 1'b0;
      game_start <= 1'b0;
      start_sync <= '0;
      sel_sync   <= '0;
    end else begin
      state      <= state_nx;
      pwr_cnt    <= pwr_cnt_nx;
      blink_cnt  <= blink_cnt_nx;
      res_cnt    <= res_cnt_nx;
      blink      <= blink_nx;
      menu_item  <= menu_item_nx;
      game_run   <= game_run_nx;
      game_start <= game_start_nx;
      start_sync <= {start_sync[1:0], gs.btn_start};
      sel_sync   <= {sel_sync[1:0], gs.btn_sel};
    end
  end

  always_comb begin
    state_nx     = state;
    pwr_cnt_nx   = '0;
    blink_cnt_nx = '0;
    res_cnt_nx   = '0;
    blink_nx     = 1'b0;
    menu_item_nx = menu_item;
    case (state)
      S_OFF: begin
        if (pwr_cnt == PWR_LAST) state_nx = S_INTRO;
        else                     pwr_cnt_nx = pwr_cnt + PW'(1);
      end
      S_INTRO: begin
        if (start_edge) begin
          state_nx = S_MENU;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_nx = ~blink;
        end else begin
          blink_nx     = blink;
          blink_cnt_nx = blink_cnt + BW'(1);
        end
      end
      S_MENU: begin
        if (start_edge)    state_nx = menu_item ? S_TUT : S_PLAY;
        else if (sel_edge) menu_item_nx = ~menu_item;
      end
      S_TUT: begin
        if (start_edge) state_nx = S_MENU;
      end
      S_PLAY: begin
        if (gs.lose_evt)     state_nx = S_LOSE;
        else if (gs.win_evt) state_nx = S_WIN;
      end
      S_WIN, S_LOSE: begin
        if (start_edge || res_cnt == RES_LAST) begin
          state_nx     = S_MENU;
          menu_item_nx = 1'b0;
        end else begin
          res_cnt_nx = res_cnt + RW'(1);
        end
      end
      default: state_nx = S_OFF;
    endcase
    game_run_nx   = (state_nx == S_PLAY);
    game_start_nx = (state == S_MENU) && (state_nx == S_PLAY);
  end

  assign gs.vga_control = state;
  assign gs.blink       = blink;
  assign gs.menu_item   = menu_item;
  assign gs.game_run    = game_run;
  assign gs.game_start  = game_start;
endmodule

// File: tb/tb_game_screen_ctrl.sv
// tb/tb_game_screen_ctrl.sv - randomized scoreboard bench for game_screen_ctrl
module tb_game_screen_ctrl;
  localparam int PWRUP  = 4;
  localparam int BLINK  = 3;
  localparam int RESULT = 5;
  localparam int OFF = 0, INTRO = 1, MENU = 2, TUT = 3, PLAY = 4, WIN = 5, LOSE = 6;

  logic clk = 1'b0;
  logic clr = 1'b0;
  game_screen_if gs();

  game_screen_ctrl #(
    .PWRUP_CYC (PWRUP),
    .BLINK_HALF(BLINK),
    .RESULT_CYC(RESULT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .gs (gs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vga;
    logic       blink;
    logic       item;
    logic       run;
    logic       start;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: edge count since reset, entry edge of the current screen,
  // and button presses scheduled to act two edges after they are first seen.
  int   m_state, m_n, m_ent;
  logic m_item, m_start;
  logic prev_s, prev_sel;
  int   start_q[$], sel_q[$];

  function automatic void model_reset();
    m_state = OFF; m_n = 0; m_ent = 0;
    m_item = 1'b0; m_start = 1'b0;
    prev_s = 1'b0; prev_sel = 1'b0;
    start_q.delete(); sel_q.delete();
    exp_q.delete();
  endfunction

  function automatic void go(input int s);
    m_state = s;
    m_ent   = m_n;
  endfunction

  function automatic void model_step();
    bit   st, se;
    exp_t e;
    m_n++;
    if (gs.btn_start && !prev_s) start_q.push_back(m_n + 2);
    if (gs.btn_sel && !prev_sel) sel_q.push_back(m_n + 2);
    prev_s   = gs.btn_start;
    prev_sel = gs.btn_sel;
    st = (start_q.size() > 0) && (start_q[0] == m_n);
    se = (sel_q.size() > 0) && (sel_q[0] == m_n);
    if (st) void'(start_q.pop_front());
    if (se) void'(sel_q.pop_front());
    m_start = 1'b0;
    case (m_state)
      OFF:   if (m_n - m_ent == PWRUP) go(INTRO);
      INTRO: if (st) go(MENU);
      MENU: begin
        if (st) begin
          if (m_item) go(TUT);
          else begin go(PLAY); m_start = 1'b1; end
        end else if (se) m_item = ~m_item;
      end
      TUT:   if (st) go(MENU);
      PLAY: begin
        if (gs.lose_evt)     go(LOSE);
        else if (gs.win_evt) go(WIN);
      end
      default: if (st || (m_n - m_ent == RESULT)) begin go(MENU); m_item = 1'b0; end
    endcase
    e.vga   = 4'(m_state);
    e.blink = (m_state == INTRO) ? 1'(((m_n - m_ent) / BLINK) % 2) : 1'b0;
    e.item  = m_item;
    e.run   = (m_state == PLAY);
    e.start = m_start;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    exp_t e;
    if (clr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (gs.vga_control !== e.vga || gs.blink !== e.blink || gs.menu_item !== e.item ||
          gs.game_run !== e.run || gs.game_start !== e.start) begin
        mismatched++;
        $display("FAIL outputs t=%0t got vga=%0d blink=%b item=%b run=%b start=%b exp vga=%0d blink=%b item=%b run=%b start=%b",
                 $time, gs.vga_control, gs.blink, gs.menu_item, gs.game_run, gs.game_start,
                 e.vga, e.blink, e.item, e.run, e.start);
      end
    end
  end

  task automatic check_zero(input string tag);
    compared++;
    if (gs.vga_control !== 4'd0 || gs.blink !== 1'b0 || gs.menu_item !== 1'b0 ||
        gs.game_run !== 1'b0 || gs.game_start !== 1'b0) begin
      mismatched++;
      $display("FAIL %s got vga=%0d blink=%b item=%b run=%b start=%b exp all zero",
               tag, gs.vga_control, gs.blink, gs.menu_item, gs.game_run, gs.game_start);
    end
  endtask

  task automatic tick(input logic s, input logic sel, input logic w, input logic l);
    @(negedge clk);
    gs.btn_start = s;
    gs.btn_sel   = sel;
    gs.win_evt   = w;
    gs.lose_evt  = l;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit is_start);
    tick(is_start, !is_start, 1'b0, 1'b0);
    idle(3);
  endtask

  // Steers the model (and hence the DUT) toward a target screen within a bounded budget.
  task automatic goto(input int target);
    for (int i = 0; i < 80 && m_state != target; i++) begin
      case (m_state)
        INTRO, TUT: press(1'b1);
        MENU:       if (m_item != (target == TUT)) press(1'b0); else press(1'b1);
        PLAY: begin
          tick(1'b0, 1'b0, target != LOSE, target == LOSE);
          idle(1);
        end
        default:    idle(1);
      endcase
    end
    if (m_state != target) begin
      compared++;
      mismatched++;
      $display("FAIL goto model screen=%0d target=%0d", m_state, target);
    end
  endtask

  initial begin
    logic s = 1'b0, sel = 1'b0;
    gs.btn_start = 1'b0; gs.btn_sel = 1'b0; gs.win_evt = 1'b0; gs.lose_evt = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    @(negedge clk) clr = 1'b1;

    goto(INTRO);
    idle(10);
    goto(MENU);
    press(1'b0);
    goto(TUT);
    goto(MENU);
    press(1'b0);
    goto(PLAY);
    idle(2);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    idle(RESULT + 3);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    press(1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    goto(MENU);
    goto(WIN);
    idle(2);
    press(1'b1);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) s = ~s;
      if ($urandom_range(4) == 0) sel = ~sel;
      tick(s, sel, $urandom_range(9) == 0, $urandom_range(13) == 0);
    end
    idle(4);

    goto(PLAY);
    @(posedge clk);
    #2 clr = 1'b0;
    gs.btn_start = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    @(negedge clk) clr = 1'b1;
    repeat (PWRUP + 8) tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    goto(MENU);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
